// File: rtl/fetch_queue.sv
// Instruction fetch queue between the imem port and IF/ID.
// Buffers {pc, instr}; flush on redirect discards all entries.
module fetch_queue #(
  parameter int DATAW = 32,
  parameter int ADDRW = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDRW-1:0]         in_pc,
  input  logic [DATAW-1:0]         in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRW-1:0]         out_pc,
  output logic [DATAW-1:0]         out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  typedef struct packed {
    logic [ADDRW-1:0] pc;
    logic [DATAW-1:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wp;
  logic [PW-1:0]   rp;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic [IW-1:0]   wi;
  logic [IW-1:0]   ri;

  assign wi    = wp[IW-1:0];
  assign ri    = rp[IW-1:0];
  assign empty = (wp == rp);
  assign full  = (wi == ri) && (wp[IW] != rp[IW]);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid & in_ready & !flush;
  assign pop       = out_valid & out_ready & !flush;

  assign out_pc    = mem[ri].pc;
  assign out_instr = mem[ri].instr;
  assign count     = wp - rp;

  // Pointer update; flush rewinds both, dropping same-cycle push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
    end
  end

  // Entry storage; cleared on reset so the head reads zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (push) begin
      mem[wi] <= '{pc: in_pc, instr: in_instr};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue.
// Hand-computed vectors, one check task for all comparisons.
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int n_chk  = 0;
  int n_pass = 0;

  fetch_queue #(
    .DATAW(32),
    .ADDRW(32),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pc(in_pc),
    .in_instr(in_instr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_instr(out_instr),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h100;
    in_instr  = 32'h0000_0013;
    out_ready = 1'b0;

    // reset held with in_valid high
    repeat (2) tick();
    check("rst_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_pc", out_pc, 0);
    check("rst_instr", out_instr, 0);
    check("rst_ready", in_ready, 1);

    // first push after release
    rst = 1'b1;
    tick();
    in_valid = 1'b0;
    check("p1_valid", out_valid, 1);
    check("p1_pc", out_pc, 32'h100);
    check("p1_instr", out_instr, 32'h13);
    check("p1_count", count, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("p1_drain", count, 0);

    // fill with backpressure
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_pc    = 32'(i * 4);
      in_instr = 32'hA000 + 32'(i);
      check("fill_ready", in_ready, 1);
      tick();
    end
    check("full_count", count, 4);
    check("full_ready", in_ready, 0);
    in_pc = 32'h10;
    tick();
    check("ovf_count", count, 4);
    check("ovf_head", out_pc, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("pop_pc", out_pc, 64'(i * 4));
      check("pop_instr", out_instr, 64'(32'hA000 + i));
      tick();
      if (i == 0) check("pop_ready", in_ready, 1);
    end
    check("pop_empty", out_valid, 0);
    check("pop_count", count, 0);

    // streaming across pointer wrap
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_pc    = 32'h1000 + 32'(i * 4);
      in_instr = 32'hB000 + 32'(i);
      tick();
      check("strm_count", count, 1);
      check("strm_pc", out_pc, 64'(32'h1000 + i * 4));
      check("strm_instr", out_instr, 64'(32'hB000 + i));
    end
    in_valid = 1'b0;
    tick();
    check("strm_end", count, 0);

    // simultaneous push/pop at count 2
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h300;
    tick();
    in_pc = 32'h304;
    tick();
    check("sim_pre", count, 2);
    in_pc     = 32'h308;
    out_ready = 1'b1;
    tick();
    check("sim_count", count, 2);
    check("sim_head", out_pc, 32'h304);
    in_valid = 1'b0;
    tick();
    check("sim_last", out_pc, 32'h308);
    tick();
    check("sim_drain", count, 0);

    // flush with push and pop presented
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_pc = 32'h400 + 32'(i * 4);
      tick();
    end
    check("fl_pre", count, 3);
    flush     = 1'b1;
    in_pc     = 32'h40C;
    out_ready = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("fl_count", count, 0);
    check("fl_valid", out_valid, 0);
    in_valid = 1'b1;
    in_pc    = 32'h200;
    in_instr = 32'h0000_0093;
    tick();
    check("fl_head", out_pc, 32'h200);
    check("fl_instr", out_instr, 32'h93);
    check("fl_count1", count, 1);

    // async reset between edges at count 3
    in_pc = 32'h204;
    tick();
    in_pc = 32'h208;
    tick();
    in_valid = 1'b0;
    check("ar_pre", count, 3);
    #1;
    rst = 1'b0;
    #1;
    check("ar_count", count, 0);
    check("ar_valid", out_valid, 0);
    check("ar_pc", out_pc, 0);
    check("ar_instr", out_instr, 0);
    check("ar_ready", in_ready, 1);
    tick();
    rst = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
